// File: rtl/alu_issue_stage.sv
// Issue register in front of the combinational ALU. It resolves operands from the
// register file, the immediate, or EX/MEM forwarding, and keeps held operands current during stalls.
module alu_issue_stage #(
  parameter int XLEN     = 32,
  parameter int IDX_W    = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [IDX_W-1:0] rs1Idx,
  input  logic [IDX_W-1:0] rs2Idx,
  input  logic [XLEN-1:0]  rs1Data,
  input  logic [XLEN-1:0]  rs2Data,
  input  logic [XLEN-1:0]  imm,
  input  logic             useImm,
  input  logic [IDX_W-1:0] rdIdxIn,
  input  logic [3:0]       aluOpIn,
  input  logic             signedIn,
  input  logic             exFwdValid,
  input  logic [IDX_W-1:0] exFwdRd,
  input  logic [XLEN-1:0]  exFwdData,
  input  logic             memFwdValid,
  input  logic [IDX_W-1:0] memFwdRd,
  input  logic [XLEN-1:0]  memFwdData,
  output logic             outValid,
  input  logic             outReady,
  output logic [XLEN-1:0]  srcA,
  output logic [XLEN-1:0]  srcB,
  output logic [3:0]       aluOp,
  output logic             signedOperation,
  output logic [IDX_W-1:0] rdIdxOut
);

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  src_a_q, src_a_d;
  logic [XLEN-1:0]  src_b_q, src_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             signed_q, signed_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] rs1_idx_q, rs1_idx_d;
  logic [IDX_W-1:0] rs2_idx_q, rs2_idx_d;
  logic             use_imm_q, use_imm_d;
  logic             accept;

  // The same priority chain serves fresh operands and held ones; 'fallback' is the value used when nothing matches.
  function automatic logic [XLEN-1:0] resolve(
    input logic [IDX_W-1:0] idx,
    input logic [XLEN-1:0]  fallback,
    input logic             ex_v,
    input logic [IDX_W-1:0] ex_rd,
    input logic [XLEN-1:0]  ex_data,
    input logic             mem_v,
    input logic [IDX_W-1:0] mem_rd,
    input logic [XLEN-1:0]  mem_data
  );
    if ((ZERO_REG != 0) && (idx == '0)) return '0;
    if (ex_v && (ex_rd == idx))         return ex_data;
    if (mem_v && (mem_rd == idx))       return mem_data;
    return fallback;
  endfunction

  assign inReady = !out_valid_q || outReady;
  assign accept  = inValid && inReady;

  always_comb begin
    out_valid_d = out_valid_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    alu_op_d    = alu_op_q;
    signed_d    = signed_q;
    rd_idx_d    = rd_idx_q;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    use_imm_d   = use_imm_q;

    if (accept) begin
      out_valid_d = 1'b1;
      src_a_d     = resolve(rs1Idx, rs1Data, exFwdValid, exFwdRd, exFwdData,
                            memFwdValid, memFwdRd, memFwdData);
      src_b_d     = useImm ? imm
                           : resolve(rs2Idx, rs2Data, exFwdValid, exFwdRd, exFwdData,
                                     memFwdValid, memFwdRd, memFwdData);
      alu_op_d    = aluOpIn;
      signed_d    = signedIn;
      rd_idx_d    = rdIdxIn;
      rs1_idx_d   = rs1Idx;
      rs2_idx_d   = rs2Idx;
      use_imm_d   = useImm;
    end else if (out_valid_q && outReady) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      // Stalled: results still arriving from EX/MEM would otherwise be lost once they retire.
      src_a_d = resolve(rs1_idx_q, src_a_q, exFwdValid, exFwdRd, exFwdData,
                        memFwdValid, memFwdRd, memFwdData);
      if (!use_imm_q) begin
        src_b_d = resolve(rs2_idx_q, src_b_q, exFwdValid, exFwdRd, exFwdData,
                          memFwdValid, memFwdRd, memFwdData);
      end
    end

    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      alu_op_q    <= '0;
      signed_q    <= 1'b0;
      rd_idx_q    <= '0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
      use_imm_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      alu_op_q    <= alu_op_d;
      signed_q    <= signed_d;
      rd_idx_q    <= rd_idx_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
      use_imm_q   <= use_imm_d;
    end
  end

  assign outValid        = out_valid_q;
  assign srcA            = src_a_q;
  assign srcB            = src_b_q;
  assign aluOp           = alu_op_q;
  assign signedOperation = signed_q;
  assign rdIdxOut        = rd_idx_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a table of forwarding/immediate vectors streamed
// back-to-back, plus hand-written reset, stall-refresh and flush sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, flush, inValid, inReady, useImm, signedIn;
  logic [4:0]  rs1Idx, rs2Idx, rdIdxIn, exFwdRd, memFwdRd, rdIdxOut;
  logic [31:0] rs1Data, rs2Data, imm, exFwdData, memFwdData, srcA, srcB;
  logic [3:0]  aluOpIn, aluOp;
  logic        exFwdValid, memFwdValid, outValid, outReady, signedOperation;

  typedef struct {
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_idx;
    logic [31:0] rs2_data;
    logic        use_imm;
    logic [31:0] imm;
    logic        ex_v;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        mem_v;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [3:0]  alu_op;
    logic        sgn;
    logic [4:0]  rd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .inValid(inValid), .inReady(inReady),
    .rs1Idx(rs1Idx), .rs2Idx(rs2Idx), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .imm(imm), .useImm(useImm), .rdIdxIn(rdIdxIn), .aluOpIn(aluOpIn), .signedIn(signedIn),
    .exFwdValid(exFwdValid), .exFwdRd(exFwdRd), .exFwdData(exFwdData),
    .memFwdValid(memFwdValid), .memFwdRd(memFwdRd), .memFwdData(memFwdData),
    .outValid(outValid), .outReady(outReady), .srcA(srcA), .srcB(srcB),
    .aluOp(aluOp), .signedOperation(signedOperation), .rdIdxOut(rdIdxOut)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [4:0] r1, input logic [31:0] d1, input logic [4:0] r2, input logic [31:0] d2,
    input logic ui, input logic [31:0] im,
    input logic ev, input logic [4:0] erd, input logic [31:0] ed,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic [3:0] op, input logic sg, input logic [4:0] rd,
    input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v.rs1_idx = r1;  v.rs1_data = d1; v.rs2_idx = r2; v.rs2_data = d2;
    v.use_imm = ui;  v.imm = im;
    v.ex_v = ev;     v.ex_rd = erd;   v.ex_data = ed;
    v.mem_v = mv;    v.mem_rd = mrd;  v.mem_data = md;
    v.alu_op = op;   v.sgn = sg;      v.rd = rd;
    v.exp_a = ea;    v.exp_b = eb;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input logic valid, input logic ready, input logic fl);
    rs1Idx = v.rs1_idx;  rs1Data = v.rs1_data;
    rs2Idx = v.rs2_idx;  rs2Data = v.rs2_data;
    useImm = v.use_imm;  imm = v.imm;
    exFwdValid = v.ex_v;   exFwdRd = v.ex_rd;   exFwdData = v.ex_data;
    memFwdValid = v.mem_v; memFwdRd = v.mem_rd; memFwdData = v.mem_data;
    aluOpIn = v.alu_op;  signedIn = v.sgn;      rdIdxIn = v.rd;
    inValid = valid;     outReady = ready;      flush = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t s, n;

  initial begin
    // Forwarding priority, zero register and immediate select, one op per cycle
    vecs[0] = mk(5'd3, 32'h11, 5'd4, 32'h44, 1'b0, 32'h0,
                 1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd3, 32'hBBBB_0002,
                 4'd0, 1'b0, 5'd1, 32'hAAAA_0001, 32'h44);
    vecs[1] = mk(5'd3, 32'h11, 5'd4, 32'h44, 1'b0, 32'h0,
                 1'b0, 5'd3, 32'hAAAA_0001, 1'b1, 5'd3, 32'hBBBB_0002,
                 4'd1, 1'b1, 5'd2, 32'hBBBB_0002, 32'h44);
    vecs[2] = mk(5'd0, 32'h55, 5'd4, 32'h44, 1'b0, 32'h0,
                 1'b1, 5'd0, 32'hAAAA_0001, 1'b1, 5'd0, 32'hBBBB_0002,
                 4'd2, 1'b0, 5'd3, 32'h0, 32'h44);
    vecs[3] = mk(5'd1, 32'h66, 5'd5, 32'h77, 1'b1, 32'hFFFF_FFF0,
                 1'b1, 5'd5, 32'hDEAD_0000, 1'b1, 5'd5, 32'hCAFE_0000,
                 4'd3, 1'b1, 5'd4, 32'h66, 32'hFFFF_FFF0);
    vecs[4] = mk(5'd8, 32'h88, 5'd9, 32'h99, 1'b0, 32'h0,
                 1'b0, 5'd9, 32'h1, 1'b1, 5'd9, 32'h0000_0999,
                 4'd4, 1'b0, 5'd5, 32'h88, 32'h0000_0999);
    vecs[5] = mk(5'd10, 32'hA0, 5'd12, 32'hC0, 1'b0, 32'h0,
                 1'b1, 5'd11, 32'hBAD0, 1'b1, 5'd13, 32'hBAD1,
                 4'd6, 1'b1, 5'd6, 32'hA0, 32'hC0);
    vecs[6] = mk(5'd14, 32'hE0, 5'd6, 32'h60, 1'b0, 32'h0,
                 1'b1, 5'd6, 32'h6E6E, 1'b1, 5'd6, 32'h6D6D,
                 4'd7, 1'b0, 5'd7, 32'hE0, 32'h6E6E);

    // Reset with an op offered: nothing captured, everything zero
    s = mk(5'd2, 32'h100, 5'd3, 32'h200, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
           4'd5, 1'b1, 5'd9, 32'h100, 32'h200);
    applyStimulus(s, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("reset_outValid", {31'b0, outValid}, 32'h0);
    checkOutput("reset_srcA", srcA, 32'h0);
    checkOutput("reset_srcB", srcB, 32'h0);
    checkOutput("reset_aluOp", {28'b0, aluOp}, 32'h0);
    checkOutput("reset_signed", {31'b0, signedOperation}, 32'h0);
    checkOutput("reset_rdIdx", {27'b0, rdIdxOut}, 32'h0);
    checkOutput("reset_inReady", {31'b0, inReady}, 32'h1);
    reset = 1'b0;
    tick();
    checkOutput("first_outValid", {31'b0, outValid}, 32'h1);
    checkOutput("first_srcA", srcA, 32'h100);
    checkOutput("first_rdIdx", {27'b0, rdIdxOut}, 32'd9);

    // Table streaming: a new op every cycle while the consumer is ready
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], 1'b1, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("vec%0d_inReady", i), {31'b0, inReady}, 32'h1);
      tick();
      checkOutput($sformatf("vec%0d_outValid", i), {31'b0, outValid}, 32'h1);
      checkOutput($sformatf("vec%0d_srcA", i), srcA, vecs[i].exp_a);
      checkOutput($sformatf("vec%0d_srcB", i), srcB, vecs[i].exp_b);
      checkOutput($sformatf("vec%0d_aluOp", i), {28'b0, aluOp}, {28'b0, vecs[i].alu_op});
      checkOutput($sformatf("vec%0d_signed", i), {31'b0, signedOperation}, {31'b0, vecs[i].sgn});
      checkOutput($sformatf("vec%0d_rdIdx", i), {27'b0, rdIdxOut}, {27'b0, vecs[i].rd});
    end

    // Consume without accept: valid drops, data held
    applyStimulus(vecs[6], 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("consume_outValid", {31'b0, outValid}, 32'h0);
    checkOutput("consume_srcA_held", srcA, 32'hE0);

    // Stall refresh on rs2=7 (EX) and rs1=2 (MEM)
    s = mk(5'd2, 32'h22, 5'd7, 32'h77, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
           4'd5, 1'b1, 5'd12, 32'h22, 32'h77);
    applyStimulus(s, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stall_load_srcB", srcB, 32'h77);
    n = mk(5'd2, 32'h999, 5'd7, 32'h999, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
           4'd3, 1'b0, 5'd20, 32'h0, 32'h0);
    applyStimulus(n, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("stall1_inReady", {31'b0, inReady}, 32'h0);
    tick();
    checkOutput("stall1_srcB", srcB, 32'h77);
    checkOutput("stall1_aluOp", {28'b0, aluOp}, 32'd5);
    n.ex_v = 1'b1; n.ex_rd = 5'd7; n.ex_data = 32'h1234;
    applyStimulus(n, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("stall2_inReady", {31'b0, inReady}, 32'h0);
    tick();
    checkOutput("stall2_srcB", srcB, 32'h1234);
    checkOutput("stall2_srcA", srcA, 32'h22);
    n.ex_v = 1'b0; n.mem_v = 1'b1; n.mem_rd = 5'd2; n.mem_data = 32'h2222;
    applyStimulus(n, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("stall3_inReady", {31'b0, inReady}, 32'h0);
    tick();
    checkOutput("stall3_srcB", srcB, 32'h1234);
    checkOutput("stall3_srcA", srcA, 32'h2222);
    checkOutput("stall3_aluOp", {28'b0, aluOp}, 32'd5);
    checkOutput("stall3_signed", {31'b0, signedOperation}, 32'h1);
    checkOutput("stall3_rdIdx", {27'b0, rdIdxOut}, 32'd12);
    checkOutput("stall3_outValid", {31'b0, outValid}, 32'h1);
    n.mem_v = 1'b0;
    applyStimulus(n, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("stall_release_outValid", {31'b0, outValid}, 32'h0);

    // Stall with immediate: srcB keeps imm, rs1=0 stays zero despite forwarding
    s = mk(5'd0, 32'h33, 5'd7, 32'h77, 1'b1, 32'hF0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
           4'd1, 1'b0, 5'd15, 32'h0, 32'hF0);
    applyStimulus(s, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("immstall_load_srcB", srcB, 32'hF0);
    checkOutput("immstall_load_srcA", srcA, 32'h0);
    s.ex_v = 1'b1; s.ex_rd = 5'd7; s.ex_data = 32'hBEEF;
    s.mem_v = 1'b1; s.mem_rd = 5'd0; s.mem_data = 32'h5555;
    applyStimulus(s, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("immstall_srcB", srcB, 32'hF0);
    checkOutput("immstall_srcA", srcA, 32'h0);
    s.ex_v = 1'b0; s.mem_v = 1'b0;
    applyStimulus(s, 1'b0, 1'b1, 1'b0);
    tick();

    // Flush with a simultaneous accept while an op is held
    s = mk(5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
           4'd2, 1'b0, 5'd21, 32'h1, 32'h2);
    applyStimulus(s, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("flush_held_outValid", {31'b0, outValid}, 32'h1);
    s.rd = 5'd22;
    applyStimulus(s, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("flush_inReady", {31'b0, inReady}, 32'h1);
    tick();
    checkOutput("flush_outValid", {31'b0, outValid}, 32'h0);
    applyStimulus(s, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("flush_after_outValid", {31'b0, outValid}, 32'h0);

    // Reset in the middle of a stall drops the held op
    applyStimulus(s, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("midreset_held", {31'b0, outValid}, 32'h1);
    applyStimulus(s, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("midreset_outValid", {31'b0, outValid}, 32'h0);
    checkOutput("midreset_srcA", srcA, 32'h0);
    checkOutput("midreset_rdIdx", {27'b0, rdIdxOut}, 32'h0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
